// File: rtl/pq_pkg.sv
// Shared types and helpers for the shift-register priority queue family.
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  // Per-cell update selection driven by the queue controller.
  typedef enum logic [1:0] {
    CELL_HOLD = 2'd0,
    CELL_LOAD = 2'd1,
    CELL_PREV = 2'd2,
    CELL_NEXT = 2'd3
  } cell_op_e;

  // Keys arrive zero-extended so one helper serves any key width up to 64.
  function automatic logic pq_better(input logic [63:0] a, input logic [63:0] b,
                                     input logic min_first);
    return min_first ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/sr_pq_p_cell.sv
// One storage cell: holds, loads the new entry, or takes a neighbour's entry.
module sr_pq_p_cell
  import pq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  cell_op_e     op,
  input  logic [W-1:0] kvi,
  input  logic         prev_v,
  input  logic [W-1:0] prev_kv,
  input  logic         next_v,
  input  logic [W-1:0] next_kv,
  output logic         v,
  output logic [W-1:0] kv
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v  <= 1'b0;
      kv <= '0;
    end else begin
      case (op)
        CELL_LOAD: begin
          v  <= 1'b1;
          kv <= kvi;
        end
        CELL_PREV: begin
          v  <= prev_v;
          kv <= prev_kv;
        end
        CELL_NEXT: begin
          v  <= next_v;
          kv <= next_kv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sr_pq_p.sv
// Parametrised shift-register priority queue with stable ordering and defined eviction.
// Optional SR_PQ_P_DROP_KV_EN adds kv_drop carrying the discarded entry.
module sr_pq_p
  import pq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int MIN_FIRST = 1,
  parameter int KEY_WIDTH = pq_pkg::KEY_WIDTH,
  parameter int VAL_WIDTH = pq_pkg::VAL_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enq,
  input  logic                                 deq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0]       kvi,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]       kvo,
  output logic                                 ovalid,
  output logic                                 empty,
  output logic                                 full,
  output logic [$clog2(DEPTH+1)-1:0]           count,
`ifdef SR_PQ_P_DROP_KV_EN
  output logic [KEY_WIDTH+VAL_WIDTH-1:0]       kv_drop,
`endif
  output logic                                 drop
);

  localparam int W  = KEY_WIDTH + VAL_WIDTH;
  localparam int CW = $clog2(DEPTH+1);

  // Index DEPTH is a permanently empty sentinel below the tail.
  logic [DEPTH:0] cv;
  logic [W-1:0]   ckv [DEPTH+1];
  logic [DEPTH:0] ins;
  logic [DEPTH:0] ins_prev;
  logic [DEPTH:0] ins_mid;
  cell_op_e       op [DEPTH];
  logic           do_deq;
  logic           drop_nxt;

  assign cv[DEPTH]  = 1'b0;
  assign ckv[DEPTH] = '0;

  // ins[i]: kvi belongs at or before cell i; monotonic since cells are sorted.
  always_comb begin
    ins = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      ins[i] = !cv[i] || pq_better(64'(kvi[W-1 -: KEY_WIDTH]),
                                   64'(ckv[i][W-1 -: KEY_WIDTH]), MIN_FIRST != 0);
    end
  end

  assign ins_prev = {ins[DEPTH-1:0], 1'b0};
  assign ins_mid  = {ins[DEPTH:1], 1'b0};
  assign do_deq   = deq && !empty;
  assign drop_nxt = enq && !deq && full;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      op[i] = CELL_HOLD;
      if (enq && do_deq) begin
        // Replace: cells ahead of the slot move up, kvi lands just before it.
        if (!ins[i+1])      op[i] = CELL_NEXT;
        else if (!ins_mid[i]) op[i] = CELL_LOAD;
      end else if (enq) begin
        if (ins_prev[i]) op[i] = CELL_PREV;
        else if (ins[i]) op[i] = CELL_LOAD;
      end else if (do_deq) begin
        op[i] = CELL_NEXT;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    logic         pv;
    logic [W-1:0] pkv;
    if (g == 0) begin : g_head
      assign pv  = 1'b0;
      assign pkv = '0;
    end else begin : g_body
      assign pv  = cv[g-1];
      assign pkv = ckv[g-1];
    end
    sr_pq_p_cell #(.W(W)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (op[g]),
      .kvi     (kvi),
      .prev_v  (pv),
      .prev_kv (pkv),
      .next_v  (cv[g+1]),
      .next_kv (ckv[g+1]),
      .v       (cv[g]),
      .kv      (ckv[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      drop  <= 1'b0;
    end else begin
      drop <= drop_nxt;
      if (enq && !do_deq && !full)  count <= count + CW'(1);
      else if (!enq && do_deq)      count <= count - CW'(1);
    end
  end

`ifdef SR_PQ_P_DROP_KV_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        kv_drop <= '0;
    else if (drop_nxt) kv_drop <= ins[DEPTH-1] ? ckv[DEPTH-1] : kvi;
    else               kv_drop <= '0;
  end
`endif

  assign kvo    = ckv[0];
  assign ovalid = cv[0];
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  deq_on_empty_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(deq && !enq && empty))
    else $warning("sr_pq_p: deq on empty queue ignored");

endmodule

// File: tb/tb_sr_pq_p.sv
// Directed bench for sr_pq_p: min/max ordering, tie FIFO, replace, eviction, reset.
module tb_sr_pq_p;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enq = 1'b0;
  logic         deq = 1'b0;
  logic [W-1:0] kvi = '0;

  logic [W-1:0] a_kvo, m_kvo, d_kvo;
  logic         a_ovalid, m_ovalid, d_ovalid;
  logic         a_empty, m_empty, d_empty;
  logic         a_full, m_full, d_full;
  logic [3:0]   a_count, m_count;
  logic [2:0]   d_count;
  logic         a_drop, m_drop, d_drop;
`ifdef SR_PQ_P_DROP_KV_EN
  logic [W-1:0] a_kvd, m_kvd, d_kvd;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  sr_pq_p #(.DEPTH(8), .MIN_FIRST(1)) u_min (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(a_kvo), .ovalid(a_ovalid), .empty(a_empty), .full(a_full),
    .count(a_count),
`ifdef SR_PQ_P_DROP_KV_EN
    .kv_drop(a_kvd),
`endif
    .drop(a_drop)
  );

  sr_pq_p #(.DEPTH(8), .MIN_FIRST(0)) u_max (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(m_kvo), .ovalid(m_ovalid), .empty(m_empty), .full(m_full),
    .count(m_count),
`ifdef SR_PQ_P_DROP_KV_EN
    .kv_drop(m_kvd),
`endif
    .drop(m_drop)
  );

  sr_pq_p #(.DEPTH(4), .MIN_FIRST(1)) u_d4 (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(d_kvo), .ovalid(d_ovalid), .empty(d_empty), .full(d_full),
    .count(d_count),
`ifdef SR_PQ_P_DROP_KV_EN
    .kv_drop(d_kvd),
`endif
    .drop(d_drop)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock with the given request; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic e, input logic d, input logic [7:0] k, input logic [7:0] v);
    enq = e;
    deq = d;
    kvi = {k, v};
    @(posedge clk);
    #1;
    enq = 1'b0;
    deq = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst_count",  32'(a_count),  32'd0);
    check("rst_empty",  32'(a_empty),  32'd1);
    check("rst_full",   32'(a_full),   32'd0);
    check("rst_ovalid", 32'(a_ovalid), 32'd0);
    check("rst_drop",   32'(a_drop),   32'd0);
    check("rst_kvo",    32'(a_kvo),    32'd0);

    // Tie FIFO
    cyc(1, 0, 8'd8, 8'd14);
    check("first_lat_kvo", 32'(a_kvo), 32'h080E);
    check("first_lat_cnt", 32'(a_count), 32'd1);
    cyc(1, 0, 8'd9, 8'd10);
    cyc(1, 0, 8'd9, 8'd11);
    cyc(1, 0, 8'd9, 8'd12);
    check("tie_count", 32'(a_count), 32'd4);
    check("tie_h0", 32'(a_kvo), 32'h080E);
    cyc(0, 1, 8'd0, 8'd0);
    check("tie_h1", 32'(a_kvo), 32'h090A);
    cyc(0, 1, 8'd0, 8'd0);
    check("tie_h2", 32'(a_kvo), 32'h090B);
    cyc(0, 1, 8'd0, 8'd0);
    check("tie_h3", 32'(a_kvo), 32'h090C);
    cyc(0, 1, 8'd0, 8'd0);
    check("tie_empty",  32'(a_empty),  32'd1);
    check("tie_ovalid", 32'(a_ovalid), 32'd0);

    // Min-first vs max-first ordering with a duplicate key
    do_reset();
    cyc(1, 0, 8'd9, 8'd1);
    cyc(1, 0, 8'd3, 8'd2);
    cyc(1, 0, 8'd7, 8'd3);
    cyc(1, 0, 8'd1, 8'd4);
    cyc(1, 0, 8'd1, 8'd11);
    check("ord_count", 32'(a_count), 32'd5);
    begin
      logic [15:0] exp_min [5] = '{16'h0104, 16'h010B, 16'h0302, 16'h0703, 16'h0901};
      logic [15:0] exp_max [5] = '{16'h0901, 16'h0703, 16'h0302, 16'h0104, 16'h010B};
      for (int i = 0; i < 5; i++) begin
        check($sformatf("ord_min%0d", i), 32'(a_kvo), 32'(exp_min[i]));
        check($sformatf("ord_max%0d", i), 32'(m_kvo), 32'(exp_max[i]));
        cyc(0, 1, 8'd0, 8'd0);
      end
    end
    check("ord_empty", 32'(m_empty), 32'd1);

    // Simultaneous enq+deq keeps count steady
    do_reset();
    cyc(1, 0, 8'd2, 8'h20);
    cyc(1, 0, 8'd5, 8'h50);
    cyc(1, 0, 8'd8, 8'h80);
    cyc(1, 1, 8'd6, 8'h60);
    check("rep_h1", 32'(a_kvo), 32'h0550);
    check("rep_c1", 32'(a_count), 32'd3);
    cyc(1, 1, 8'd1, 8'h10);
    check("rep_h2", 32'(a_kvo), 32'h0110);
    check("rep_c2", 32'(a_count), 32'd3);
    cyc(0, 1, 8'd0, 8'd0);
    check("rep_h3", 32'(a_kvo), 32'h0660);
    cyc(0, 1, 8'd0, 8'd0);
    check("rep_h4", 32'(a_kvo), 32'h0880);

    // Full-queue eviction on the DEPTH=4 instance
    do_reset();
    cyc(1, 0, 8'd10, 8'd1);
    cyc(1, 0, 8'd20, 8'd2);
    cyc(1, 0, 8'd30, 8'd3);
    cyc(1, 0, 8'd40, 8'd4);
    check("ev_full", 32'(d_full), 32'd1);
    check("ev_nodrop", 32'(d_drop), 32'd0);
    cyc(1, 0, 8'd15, 8'd5);
    check("ev_drop1", 32'(d_drop), 32'd1);
    check("ev_cnt1", 32'(d_count), 32'd4);
`ifdef SR_PQ_P_DROP_KV_EN
    check("ev_kvd1", 32'(d_kvd), 32'h2804);
`endif
    cyc(0, 0, 8'd0, 8'd0);
    check("ev_pulse", 32'(d_drop), 32'd0);
`ifdef SR_PQ_P_DROP_KV_EN
    check("ev_kvd0", 32'(d_kvd), 32'd0);
`endif
    cyc(1, 0, 8'd50, 8'd6);
    check("ev_drop2", 32'(d_drop), 32'd1);
`ifdef SR_PQ_P_DROP_KV_EN
    check("ev_kvd2", 32'(d_kvd), 32'h3206);
`endif
    check("ev_head", 32'(d_kvo), 32'h0A01);
    cyc(1, 1, 8'd25, 8'd7);
    check("ev_repl_drop", 32'(d_drop), 32'd0);
    check("ev_repl_cnt", 32'(d_count), 32'd4);
    begin
      logic [15:0] exp_d4 [4] = '{16'h0F05, 16'h1402, 16'h1907, 16'h1E03};
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ev_pop%0d", i), 32'(d_kvo), 32'(exp_d4[i]));
        cyc(0, 1, 8'd0, 8'd0);
      end
    end
    check("ev_empty", 32'(d_empty), 32'd1);

    // Empty-queue corner cases
    do_reset();
    cyc(0, 1, 8'd0, 8'd0);
    check("de_empty", 32'(a_empty), 32'd1);
    check("de_count", 32'(a_count), 32'd0);
    cyc(1, 1, 8'd4, 8'd4);
    check("ed_count", 32'(a_count), 32'd1);
    check("ed_kvo", 32'(a_kvo), 32'h0404);
    check("ed_ovalid", 32'(a_ovalid), 32'd1);

    // Reset mid-stream beats a pending enq
    cyc(1, 0, 8'd6, 8'd6);
    cyc(1, 0, 8'd7, 8'd7);
    check("mr_pre", 32'(a_count), 32'd3);
    cyc(1, 0, 8'd8, 8'd8);
    check("mr_d4full", 32'(d_full), 32'd1);
    rst_n = 1'b0;
    cyc(1, 0, 8'd1, 8'd1);
    rst_n = 1'b1;
    check("mr_count",  32'(a_count),  32'd0);
    check("mr_ovalid", 32'(a_ovalid), 32'd0);
    check("mr_drop",   32'(d_drop),   32'd0);
    check("mr_d4cnt",  32'(d_count),  32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
